// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler
//   Schedules obstacle spawns for the dinosaur game. Each interval is built
//   from the 4-bit LFSR value with forced-one LSBs ({rnd, 1111} = 15..255
//   frames). Frame ticks are counted, a spawn is requested over a
//   valid/ready handshake, and the LFSR is stepped once per new interval.
//
//   Optional build macro SPAWN_SPEEDUP_EN adds a 2-bit difficulty 'level'
//   input that shrinks each interval by a right shift. The result is clamped
//   to a floor of 2^FILL_W-1 frames.
module obstacle_spawn_scheduler #(
    parameter int RND_W  = 4,
    parameter int FILL_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    frame_tick,
    input  logic [RND_W-1:0]        rnd_in,
`ifdef SPAWN_SPEEDUP_EN
    input  logic [1:0]              level,
`endif
    output logic                    rng_step,
    output logic                    spawn_valid,
    input  logic                    spawn_ready,
    output logic [RND_W+FILL_W-1:0] gap_out
);

    localparam int GAP_W = RND_W + FILL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_SPAWN
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [GAP_W-1:0]   r_count;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_base_gap;
    logic [GAP_W-1:0]   w_load_gap;
    logic               w_last_tick;

    // Raw interval: random value in the MSBs, forced ones in the LSBs.
    assign w_base_gap = {rnd_in, {FILL_W{1'b1}}};

`ifdef SPAWN_SPEEDUP_EN
    localparam logic [GAP_W-1:0] MIN_GAP = GAP_W'((1 << FILL_W) - 1);
    logic [GAP_W-1:0] w_shift_gap;

    // Shorten the interval by difficulty, but never below the base minimum.
    assign w_shift_gap = w_base_gap >> level;
    assign w_load_gap  = (w_shift_gap < MIN_GAP) ? MIN_GAP : w_shift_gap;
`else
    assign w_load_gap = w_base_gap;
`endif

    // The tick that completes the interval; gap is always >= 15, so no wrap.
    assign w_last_tick = frame_tick && (r_count == r_gap - GAP_W'(1));

    // State, tick counter and interval registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its sources, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_next_state;
            if (!run) begin
                // Leaving play: discard progress, keep the last interval.
                r_count <= '0;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        r_gap   <= w_load_gap;
                        r_count <= '0;
                    end
                    S_COUNT: begin
                        if (frame_tick) begin
                            r_count <= r_count + GAP_W'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Next-state logic and Moore outputs.
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        rng_step     = (r_state == S_LOAD);
        spawn_valid  = (r_state == S_SPAWN);
        if (!run) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next_state = S_LOAD;
                S_LOAD:  w_next_state = S_COUNT;
                S_COUNT: if (w_last_tick) w_next_state = S_SPAWN;
                S_SPAWN: if (spawn_ready) w_next_state = S_LOAD;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    assign gap_out = r_gap;

endmodule

// File: doc/obstacle_spawn_scheduler.md
Name: obstacle_spawn_scheduler

Overview:
Sequences the 4-bit LFSR random generator to schedule obstacle spawns in the dinosaur game. Each spawn interval is built as {rnd, 4'b1111}, giving 15..255 frames. The block counts frame ticks, issues a spawn request to the obstacle manager with a valid/ready handshake, then steps the LFSR for the next interval. It sits between the random generator (drives its enable) and the obstacle/sprite logic.

Parameters:
RND_W, 4, width of random value from LFSR (bits q7..q4)
FILL_W, 4, number of forced-one LSBs appended to random value; interval width = RND_W+FILL_W

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  game running level; low forces IDLE
frame_tick  input  1  one-cycle pulse per display frame
rnd_in  input  RND_W  current LFSR value, {q7,q6,q5,q4}
rng_step  output  1  LFSR advance enable; high only in LOAD
spawn_valid  output  1  spawn request to obstacle manager
spawn_ready  input  1  obstacle manager accepts spawn
gap_out  output  RND_W+FILL_W  interval currently being counted

Behaviour:
- One clock; reset synchronous, active-high (interface decision, fixed).
- Priority: reset > run==0 > normal FSM.
- Reset: state=IDLE, count=0, gap_out=0, spawn_valid=0, rng_step=0.
- States: IDLE, LOAD, COUNT, SPAWN. spawn_valid and rng_step are Moore outputs.
- IDLE: run==1 -> LOAD next cycle. Otherwise stay.
- LOAD (exactly 1 cycle): gap_out <= {rnd_in, FILL_W ones}; count <= 0; rng_step=1. rnd_in is sampled before the LFSR advances, so the LFSR steps once per LOAD. -> COUNT.
- COUNT: each frame_tick increments count. When frame_tick arrives with count == gap_out-1, go to SPAWN. Spawn follows exactly gap_out counted ticks after LOAD. frame_tick during LOAD or SPAWN is ignored.
- SPAWN: spawn_valid=1, held until spawn_ready==1. Handshake completes in a cycle where both are high -> LOAD. Ticks during backpressure are not counted.
- count is RND_W+FILL_W bits wide. gap_out >= 2^FILL_W-1, so wrap cannot occur. gap_out holds its value until the next LOAD.
- run falls in any state: IDLE next cycle. A pending spawn is discarded and spawn_valid drops. count is cleared. gap_out is held. A later run rise restarts with LOAD using a new rnd_in.
- Spawn_ready high together with run low: IDLE wins, and the handshake is not counted.
- Reset mid-operation returns all outputs to reset values on the next edge.
- Timeline: run rise at edge N gives LOAD in cycle N+1 and COUNT from N+2. spawn_valid rises one cycle after the counted final tick.

Optional Feature:
SPAWN_SPEEDUP_EN
- Defined: adds input level (2 bits, difficulty). In LOAD, gap_out <= max({rnd_in, ones} >> level, 2^FILL_W-1), so the interval never falls below 15 by default. level is sampled only in LOAD.
- Undefined: no level port; gap_out = {rnd_in, ones} unchanged.

Test Plan:
- Reset asserted 3 cycles with run=1 and frame_tick toggling -> spawn_valid=0, rng_step=0, gap_out=0 throughout; IDLE held.
- run=1, rnd_in=0, spawn_ready=1 -> gap_out=15; rng_step high for 1 cycle; spawn_valid high 1 cycle after the 15th tick; immediate LOAD.
- rnd_in=4'hF -> gap_out=255; spawn after exactly 255 ticks; 254 ticks produce no spawn.
- spawn_ready low for 10 cycles with 5 frame_ticks in SPAWN -> spawn_valid held 10 cycles; next interval counts from 0, so the 5 ticks are lost.
- run dropped after 7 of 15 ticks, raised 3 cycles later -> IDLE next cycle; new LOAD with rng_step pulse; full new interval counted.
- SPAWN_SPEEDUP_EN, level=2: rnd_in=4'hF gives gap_out=63; rnd_in=0 gives gap_out=15 (clamped).
